// File: rtl/wb_select_stage_pkg.sv
// Shared encodings for the writeback select stage: source indices, load types, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_select_stage_pkg;

    // Writeback source indices (slot positions in the flattened source bus)
    localparam int WSEL_ALU  = 0;
    localparam int WSEL_RAM  = 1;
    localparam int WSEL_PC   = 2;
    localparam int WSEL_SEXT = 3;
    localparam int WSEL_MD   = 4;

    // Load-type encodings; unlisted codes behave as a full word load
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_MD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_select_stage_load_align_ext.sv
// Aligns a sub-word load out of a RAM word and sign/zero-extends it to DATA_W.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module load_align_ext
    import wb_select_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] ext_dat
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    // Pick the addressed byte/half lane, then extend according to the load type
    always_comb begin
        shifted = word >> {addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_lo[1] ? word[31:16] : word[15:0];
        unique case (ld_type)
            LD_B:    ext_dat = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BU:   ext_dat = {{(DATA_W-8){1'b0}}, byte_v};
            LD_H:    ext_dat = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_HU:   ext_dat = {{(DATA_W-16){1'b0}}, half_v};
            default: ext_dat = word;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback stage: selects/extends the writeback value, stalls for mul/div results, counts retires.
// Latency: 1 cycle from accept to rf_we/fwd_valid; mul/div writes back the cycle after md_valid.
// Backpressure: in_ready drops while a mul/div result is pending; flush drops the offered instruction.
module wb_select_stage
    import wb_select_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_we,
    input  logic [RA_W-1:0]           in_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [2:0]                in_ld_type,
    input  logic [1:0]                in_addr_lo,
    input  logic                      md_valid,
    input  logic [DATA_W-1:0]         md_result,
    output logic                      rf_we,
    output logic [RA_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      fwd_valid,
    output logic [CNT_W-1:0]          retire_cnt
);

    wb_state_e         state_q, state_d;
    logic              vld_q, vld_d;
    logic              we_q, we_d;
    logic [RA_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic [DATA_W-1:0] ram_ext;
    logic [DATA_W-1:0] sel_dat;
    logic              is_md;
    logic              accept;

    load_align_ext #(
        .DATA_W (DATA_W)
    ) u_load_align_ext (
        .word    (in_src[WSEL_RAM*DATA_W +: DATA_W]),
        .addr_lo (in_addr_lo),
        .ld_type (in_ld_type),
        .ext_dat (ram_ext)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign is_md    = (WSEL_MD < NUM_SRC) && (in_sel == SEL_W'(WSEL_MD));

    // Source mux; out-of-range selects and the MD slot contribute zero
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i != WSEL_MD && in_sel == SEL_W'(i)) begin
                sel_dat = (i == WSEL_RAM) ? ram_ext : in_src[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: flush beats everything, IDLE accepts, WAIT_MD waits for the mul/div pulse
    always_comb begin
        state_d      = state_q;
        vld_d        = 1'b0;
        we_d         = we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        retire_cnt_d = retire_cnt_q + CNT_W'(vld_q);
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_d    = in_we;
                        waddr_d = in_waddr;
                        if (is_md) begin
                            state_d = ST_WAIT_MD;
                        end else begin
                            vld_d   = 1'b1;
                            wdata_d = sel_dat;
                        end
                    end
                end
                ST_WAIT_MD: begin
                    if (md_valid) begin
                        vld_d   = 1'b1;
                        wdata_d = md_result;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage register, FSM state and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vld_q        <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Outputs are zero whenever the stage holds no writeback, so stale MD address never leaks out
    assign fwd_valid  = vld_q;
    assign rf_we      = vld_q && we_q && (waddr_q != '0);
    assign rf_waddr   = vld_q ? waddr_q : '0;
    assign rf_wdata   = vld_q ? wdata_q : '0;
    assign retire_cnt = retire_cnt_q;

endmodule
